product_accumulator_stage: RTL and testbench

//  Downstream consumer of the registered 64-bit products from the CSA tree multiplier stage.

---
 rtl/product_accumulator_stage.sv | 150 +++++++++++++++
 tb/tb_product_accumulator_stage.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator_stage.sv
// Product accumulator stage: sums a programmed number of multiplier products
// into a wide accumulator and presents each job total on a valid/ready port.
`timescale 1ns/1ps
module product_accumulator_stage #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 8
) (
    input  logic              slow_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    output logic              dropped,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_remaining;
    logic [ACC_W-1:0] r_acc_out;
    logic             r_overflow;
    logic             r_dropped;
    logic             r_out_valid;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [ACC_W-1:0] w_acc_out_nxt;
    logic             w_overflow_nxt;
    logic             w_dropped_nxt;
    logic             w_out_valid_nxt;
    logic             w_load;
    logic             w_last;
    logic [ACC_W:0]   w_sum;

    // Extra top bit of the sum is the carry out of the accumulator width.
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign w_last = (r_remaining == CNT_ONE);

    // Output handshake: a transfer happens on a rising edge where out_valid and
    // out_ready are both high; acc_out and overflow stay stable while waiting.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_remaining_nxt = r_remaining;
        w_acc_out_nxt   = r_acc_out;
        w_overflow_nxt  = r_overflow;
        w_dropped_nxt   = r_dropped;
        w_out_valid_nxt = r_out_valid;
        w_load          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_load = start;
            end
            S_ACCUM: begin
                if (prod_valid) begin
                    w_acc_nxt       = w_sum[ACC_W-1:0];
                    w_remaining_nxt = r_remaining - CNT_ONE;
                    if (w_sum[ACC_W]) begin
                        w_overflow_nxt = 1'b1;
                    end
                    if (w_last) begin
                        w_acc_out_nxt   = w_sum[ACC_W-1:0];
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (start) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt     = S_IDLE;
                        w_out_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase

        // A zero-length job skips accumulation and offers a zero sum at once.
        if (w_load) begin
            w_overflow_nxt = 1'b0;
            w_dropped_nxt  = 1'b0;
            if (len != '0) begin
                w_acc_nxt       = '0;
                w_remaining_nxt = len;
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = S_ACCUM;
            end else begin
                w_acc_out_nxt   = '0;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_DRAIN;
            end
        end

        if (prod_valid && (r_state != S_ACCUM)) begin
            w_dropped_nxt = 1'b1;
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_acc_out   <= '0;
            r_overflow  <= 1'b0;
            r_dropped   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_remaining <= w_remaining_nxt;
            r_acc_out   <= w_acc_out_nxt;
            r_overflow  <= w_overflow_nxt;
            r_dropped   <= w_dropped_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign out_valid = r_out_valid;
    assign acc_out   = r_acc_out;
    assign overflow  = r_overflow;
    assign dropped   = r_dropped;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_product_accumulator_stage.sv
// Bench for product_accumulator_stage: a 72-bit and a 65-bit accumulator share
// stimulus; completed sums are checked against an expected queue.
`timescale 1ns/1ps
module tb_product_accumulator_stage;
  localparam int PROD_W  = 64;
  localparam int ACC_W   = 72;
  localparam int ACC_W_S = 65;
  localparam int CNT_W   = 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // clock / reset
  logic slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  len = '0;
  logic              prod_valid = 1'b0;
  logic [PROD_W-1:0] prod = '0;
  logic              out_ready = 1'b0;

  logic               out_valid, overflow, dropped, busy;
  logic [ACC_W-1:0]   acc_out;
  logic [1:0]         dbg_state;
  logic               s_out_valid, s_overflow, s_dropped, s_busy;
  logic [ACC_W_S-1:0] s_acc_out;
  logic [1:0]         s_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0]   exp_q[$];
  logic [ACC_W_S-1:0] exp_s_q[$];

  product_accumulator_stage #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .slow_clk(slow_clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .out_ready(out_ready),
    .out_valid(out_valid), .acc_out(acc_out), .overflow(overflow),
    .dropped(dropped), .busy(busy), .dbg_state(dbg_state)
  );

  product_accumulator_stage #(.PROD_W(PROD_W), .ACC_W(ACC_W_S), .CNT_W(CNT_W)) dut_s (
    .slow_clk(slow_clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .out_ready(out_ready),
    .out_valid(s_out_valid), .acc_out(s_acc_out), .overflow(s_overflow),
    .dropped(s_dropped), .busy(s_busy), .dbg_state(s_dbg_state)
  );

  // scoreboard: a handshake is pending at the negedge before the edge that completes it
  always @(negedge slow_clk) begin
    logic [ACC_W-1:0]   e;
    logic [ACC_W_S-1:0] es;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_main unexpected output acc_out=%0h", acc_out);
      end else begin
        e = exp_q.pop_front();
        if (acc_out !== e) begin
          errors++;
          $display("FAIL sb_main acc_out got=%0h exp=%0h", acc_out, e);
        end
      end
    end
    if (!rst && s_out_valid && out_ready) begin
      checks++;
      if (exp_s_q.size() == 0) begin
        errors++;
        $display("FAIL sb_small unexpected output acc_out=%0h", s_acc_out);
      end else begin
        es = exp_s_q.pop_front();
        if (s_acc_out !== es) begin
          errors++;
          $display("FAIL sb_small acc_out got=%0h exp=%0h", s_acc_out, es);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic push_exp(input logic [ACC_W-1:0] v, input logic [ACC_W_S-1:0] vs);
    exp_q.push_back(v);
    exp_s_q.push_back(vs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({out_valid, acc_out, overflow, dropped, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b acc=%0h ov=%b dr=%b busy=%b exp all 0",
               out_valid, acc_out, overflow, dropped, busy);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
    end
    checks++;
    if ({s_out_valid, s_acc_out, s_overflow, s_dropped, s_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_small got acc=%0h exp 0", s_acc_out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    start = 1'b1;
    len = 8'd3;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || dbg_state !== ST_ACCUM) begin
      errors++;
      $display("FAIL basic_start busy=%b state=%0d exp busy=1 state=%0d", busy, dbg_state, ST_ACCUM);
    end
    prod_valid = 1'b1;
    prod = 64'd10;
    step();
    prod = 64'd20;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid got=%b exp=0", out_valid);
    end
    prod = 64'd30;
    push_exp(72'd60, 65'd60);
    step();
    prod_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 72'd60 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_result v=%b acc=%0d ov=%b exp v=1 acc=60 ov=0", out_valid, acc_out, overflow);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL basic_idle v=%b busy=%b state=%0d exp 0 0 0", out_valid, busy, dbg_state);
    end
  endtask

  task automatic test_gaps();
    int unsigned vals[4];
    logic [ACC_W-1:0] sum;
    vals = '{5, 0, 7, 9};
    sum = '0;
    out_ready = 1'b1;
    start = 1'b1;
    len = 8'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod_valid = 1'b1;
      prod = 64'(vals[i]);
      sum = sum + 72'(vals[i]);
      if (i == 3) push_exp(sum, sum[ACC_W_S-1:0]);
      step();
      prod_valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          checks++;
          if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL gaps_busy idx=%0d gap=%0d busy=%b v=%b exp busy=1 v=0", i, g, busy, out_valid);
          end
          step();
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 72'd21 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gaps_result v=%b acc=%0d busy=%b exp v=1 acc=21 busy=1", out_valid, acc_out, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL gaps_done busy=%b exp=0", busy);
    end
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0]   e;
    logic [ACC_W_S-1:0] es;
    e = 72'hFF_FFFF_FFFF_FFFF_FFFF & {8'd0, {64{1'b1}}};
    e = e * 72'd3;
    es = 65'h0_FFFF_FFFF_FFFF_FFFD;
    out_ready = 1'b1;
    start = 1'b1;
    len = 8'd3;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = '1;
    step();
    step();
    push_exp(e, es);
    step();
    prod_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b1 || s_acc_out !== es || s_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_small v=%b acc=%0h ov=%b exp v=1 acc=%0h ov=1", s_out_valid, s_acc_out, s_overflow, es);
    end
    checks++;
    if (acc_out !== e || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wide acc=%0h ov=%b exp acc=%0h ov=0", acc_out, overflow, e);
    end
    step();
    checks++;
    if (s_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got=%b exp=1", s_overflow);
    end
    start = 1'b1;
    len = 8'd1;
    step();
    start = 1'b0;
    checks++;
    if (s_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got=%b exp=0", s_overflow);
    end
    prod_valid = 1'b1;
    prod = 64'd4;
    push_exp(72'd4, 65'd4);
    step();
    prod_valid = 1'b0;
    step();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    start = 1'b1;
    len = 8'd2;
    step();
    start = 1'b0;
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL hold_dropped_init got=%b exp=0", dropped);
    end
    prod_valid = 1'b1;
    prod = 64'd1;
    step();
    prod = 64'd2;
    push_exp(72'd3, 65'd3);
    step();
    prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || acc_out !== 72'd3) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d v=%b acc=%0d exp v=1 acc=3", i, out_valid, acc_out);
      end
      prod_valid = (i == 2);
      prod = 64'd99;
      step();
    end
    prod_valid = 1'b0;
    checks++;
    if (dropped !== 1'b1 || out_valid !== 1'b1 || acc_out !== 72'd3) begin
      errors++;
      $display("FAIL hold_dropped dr=%b v=%b acc=%0d exp dr=1 v=1 acc=3", dropped, out_valid, acc_out);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || dropped !== 1'b1) begin
      errors++;
      $display("FAIL hold_after v=%b dr=%b exp v=0 dr=1", out_valid, dropped);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    start = 1'b1;
    len = 8'd1;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 64'd11;
    push_exp(72'd11, 65'd11);
    step();
    prod_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    len = 8'd0;
    push_exp(72'd0, 65'd0);
    step();
    start = 1'b0;
    checks++;
    if (dbg_state !== ST_DRAIN || out_valid !== 1'b1 || acc_out !== 72'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_zero state=%0d v=%b acc=%0d ov=%b exp state=%0d v=1 acc=0 ov=0",
               dbg_state, out_valid, acc_out, overflow, ST_DRAIN);
    end
    step();
    checks++;
    if (dbg_state !== ST_IDLE || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_zero_done state=%0d v=%b exp state=0 v=0", dbg_state, out_valid);
    end
    out_ready = 1'b0;
    start = 1'b1;
    len = 8'd1;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 64'd12;
    push_exp(72'd12, 65'd12);
    step();
    prod_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    len = 8'd2;
    step();
    start = 1'b0;
    checks++;
    if (dbg_state !== ST_ACCUM || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load state=%0d v=%b busy=%b exp state=%0d v=0 busy=1", dbg_state, out_valid, busy, ST_ACCUM);
    end
    prod_valid = 1'b1;
    prod = 64'd3;
    step();
    prod = 64'd4;
    push_exp(72'd7, 65'd7);
    step();
    prod_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 72'd7) begin
      errors++;
      $display("FAIL b2b_second v=%b acc=%0d exp v=1 acc=7", out_valid, acc_out);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start = 1'b1;
    len = 8'd3;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 64'd100;
    step();
    prod = 64'd200;
    step();
    prod_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, acc_out, overflow, dropped, busy} !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid v=%b acc=%0h ov=%b dr=%b busy=%b state=%0d exp all 0",
               out_valid, acc_out, overflow, dropped, busy, dbg_state);
    end
    step();
    rst = 1'b0;
    step();
    start = 1'b1;
    len = 8'd1;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 64'd7;
    push_exp(72'd7, 65'd7);
    step();
    prod_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 72'd7) begin
      errors++;
      $display("FAIL rst_fresh v=%b acc=%0d exp v=1 acc=7", out_valid, acc_out);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    step();
    checks++;
    if (exp_q.size() != 0 || exp_s_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d/%0d pending exp 0", exp_q.size(), exp_s_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog timeout got=%0t exp completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
